// File: rtl/xcorr_pkg.sv
// Shared widths and the result record for the cross-correlation peak detector.
package xcorr_pkg;

  localparam int XCORR_IDX_W = 10;
  localparam int XCORR_MAG_W = 32;

  typedef struct packed {
    logic [XCORR_MAG_W-1:0] mag;
    logic [XCORR_IDX_W-1:0] idx;
    logic [4:0]             exp;
    logic                   det;
    logic                   err;
  } xcorr_peak_t;

endpackage

// File: rtl/xcorr_mag_sq.sv
// Three-register |x|^2 pipeline (input, squares, sum) with valid/eop/exponent
// carried alongside the data.
module xcorr_mag_sq
  import xcorr_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ival,
  input  logic signed [15:0]     idata_i,
  input  logic signed [15:0]     idata_q,
  input  logic [4:0]             iexp,
  input  logic                   ieop,
  output logic                   ovld,
  output logic                   oeop,
  output logic [4:0]             oexp,
  output logic [XCORR_MAG_W-1:0] omag
);

  function automatic logic signed [31:0] sq32(input logic signed [15:0] x);
    logic signed [31:0] xe;
    xe = {{16{x[15]}}, x};
    return xe * xe;
  endfunction

  logic signed [15:0]     i_p0_q, i_p0_d, q_p0_q, q_p0_d;
  logic [4:0]             exp_p0_q, exp_p0_d, exp_p1_q, exp_p1_d, exp_p2_q, exp_p2_d;
  logic                   vld_p0_q, vld_p0_d, vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
  logic                   eop_p0_q, eop_p0_d, eop_p1_q, eop_p1_d, eop_p2_q, eop_p2_d;
  logic signed [31:0]     i_sq_p1_q, i_sq_p1_d, q_sq_p1_q, q_sq_p1_d;
  logic [XCORR_MAG_W-1:0] mag_p2_q, mag_p2_d;

  always_comb begin
    // p0: sample capture
    i_p0_d    = idata_i;
    q_p0_d    = idata_q;
    exp_p0_d  = iexp;
    vld_p0_d  = ival;
    eop_p0_d  = ival & ieop;
    // p1: squares; each is at most 2^30 so the signed 32-bit product is exact
    i_sq_p1_d = sq32(i_p0_q);
    q_sq_p1_d = sq32(q_p0_q);
    exp_p1_d  = exp_p0_q;
    vld_p1_d  = vld_p0_q;
    eop_p1_d  = eop_p0_q;
    // p2: unsigned sum, peaks at 0x80000000 so it never wraps
    mag_p2_d  = $unsigned(i_sq_p1_q) + $unsigned(q_sq_p1_q);
    exp_p2_d  = exp_p1_q;
    vld_p2_d  = vld_p1_q;
    eop_p2_d  = eop_p1_q;
  end

  always_ff @(posedge clk) begin
    i_p0_q    <= i_p0_d;
    q_p0_q    <= q_p0_d;
    exp_p0_q  <= exp_p0_d;
    i_sq_p1_q <= i_sq_p1_d;
    q_sq_p1_q <= q_sq_p1_d;
    exp_p1_q  <= exp_p1_d;
    mag_p2_q  <= mag_p2_d;
    exp_p2_q  <= exp_p2_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0_q <= 1'b0;
      eop_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
      eop_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      eop_p2_q <= 1'b0;
    end else begin
      vld_p0_q <= vld_p0_d;
      eop_p0_q <= eop_p0_d;
      vld_p1_q <= vld_p1_d;
      eop_p1_q <= eop_p1_d;
      vld_p2_q <= vld_p2_d;
      eop_p2_q <= eop_p2_d;
    end
  end

  assign ovld = vld_p2_q;
  assign oeop = eop_p2_q;
  assign oexp = exp_p2_q;
  assign omag = mag_p2_q;

endmodule

// File: rtl/xcorr_peak_detect.sv
// Per-frame |x|^2 peak search over the correlator IFFT output.
// Build option XCORR_PEAK_PAR_EN adds a peak-to-average gate on the detection flag.
module xcorr_peak_detect
  import xcorr_pkg::*;
#(
  parameter int IDX_W     = 10,
  parameter int MAG_W     = 32,
  parameter int PAR_SHIFT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ival,
  input  logic signed [15:0] idata_i,
  input  logic signed [15:0] idata_q,
  input  logic [4:0]         iexp,
  input  logic               ieop,
  input  logic [MAG_W-1:0]   threshold,
  output logic [MAG_W-1:0]   opeak_mag,
  output logic [IDX_W-1:0]   opeak_idx,
  output logic [4:0]         oexp,
  output logic               odet,
  output logic               oerr,
  output logic               oval
);

  localparam int ACC_W = MAG_W + IDX_W;
  localparam logic [IDX_W-1:0] IDX_MAX = '1;

  // The shifted peak must fit in the accumulator width without truncation.
  if (PAR_SHIFT < 0 || PAR_SHIFT > IDX_W) begin : g_bad_par_shift
    $error("PAR_SHIFT must lie in 0..IDX_W");
  end

  logic             m_vld, m_eop;
  logic [4:0]       m_exp;
  logic [MAG_W-1:0] m_mag;

  xcorr_mag_sq u_mag_sq (
    .clk     (clk),
    .rst     (rst),
    .ival    (ival),
    .idata_i (idata_i),
    .idata_q (idata_q),
    .iexp    (iexp),
    .ieop    (ieop),
    .ovld    (m_vld),
    .oeop    (m_eop),
    .oexp    (m_exp),
    .omag    (m_mag)
  );

  logic [IDX_W-1:0] cnt_q, cnt_d, pk_idx_q, pk_idx_d, cand_idx;
  logic             full_q, full_d, err_q, err_d, oval_q, oval_d;
  logic [MAG_W-1:0] pk_mag_q, pk_mag_d, cand_mag;
  logic             first, upd, cand_err, det;
  xcorr_peak_t      res_q, res_d;
`ifdef XCORR_PEAK_PAR_EN
  logic [ACC_W-1:0] sum_q, sum_d, cand_sum;
`endif

  always_comb begin
    // full_q distinguishes a saturated counter from a fresh frame at index 0
    first    = (cnt_q == '0) && !full_q;
    upd      = first || (m_mag > pk_mag_q);
    cand_mag = upd ? m_mag : pk_mag_q;
    cand_idx = upd ? cnt_q : pk_idx_q;
    cand_err = err_q | full_q;
`ifdef XCORR_PEAK_PAR_EN
    cand_sum = first ? ACC_W'(m_mag) : sum_q + ACC_W'(m_mag);
    det      = (cand_mag > threshold) &&
               ((ACC_W'(cand_mag) << PAR_SHIFT) > cand_sum);
    sum_d    = sum_q;
`else
    det      = cand_mag > threshold;
`endif
    cnt_d    = cnt_q;
    full_d   = full_q;
    err_d    = err_q;
    pk_mag_d = pk_mag_q;
    pk_idx_d = pk_idx_q;
    res_d    = res_q;
    oval_d   = 1'b0;

    if (m_vld) begin
      if (m_eop) begin
        cnt_d     = '0;
        full_d    = 1'b0;
        err_d     = 1'b0;
`ifdef XCORR_PEAK_PAR_EN
        sum_d     = '0;
`endif
        res_d.mag = cand_mag;
        res_d.idx = XCORR_IDX_W'(cand_idx);
        res_d.exp = m_exp;
        res_d.det = det;
        res_d.err = cand_err;
        oval_d    = 1'b1;
      end else begin
        pk_mag_d = cand_mag;
        pk_idx_d = cand_idx;
        err_d    = cand_err;
`ifdef XCORR_PEAK_PAR_EN
        sum_d    = cand_sum;
`endif
        if (cnt_q == IDX_MAX) full_d = 1'b1;
        else                  cnt_d  = cnt_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      full_q   <= 1'b0;
      err_q    <= 1'b0;
      pk_mag_q <= '0;
      pk_idx_q <= '0;
      res_q    <= '0;
      oval_q   <= 1'b0;
`ifdef XCORR_PEAK_PAR_EN
      sum_q    <= '0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      err_q    <= err_d;
      pk_mag_q <= pk_mag_d;
      pk_idx_q <= pk_idx_d;
      res_q    <= res_d;
      oval_q   <= oval_d;
`ifdef XCORR_PEAK_PAR_EN
      sum_q    <= sum_d;
`endif
    end
  end

  assign opeak_mag = res_q.mag;
  assign opeak_idx = res_q.idx[IDX_W-1:0];
  assign oexp      = res_q.exp;
  assign odet      = res_q.det;
  assign oerr      = res_q.err;
  assign oval      = oval_q;

endmodule

// File: tb/tb_xcorr_peak_detect.sv
// Bench for xcorr_peak_detect: frame-level reference model, vector table and
// hand-written corner sequences; a second instance with IDX_W=3 covers oversize frames.
module tb_xcorr_peak_detect;

  localparam int PAR_SHIFT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, ival, ieop;
  logic signed [15:0] di, dq;
  logic [4:0]         iexp;
  logic [31:0]        threshold;

  logic [31:0] opeak_mag;
  logic [9:0]  opeak_idx;
  logic [4:0]  oexp;
  logic        odet, oerr, oval;

  logic [31:0] p3_mag;
  logic [2:0]  p3_idx;
  logic [4:0]  p3_exp;
  logic        p3_det, p3_err, p3_val;

  xcorr_peak_detect #(.IDX_W(10), .MAG_W(32), .PAR_SHIFT(PAR_SHIFT)) dut (
    .clk(clk), .rst(rst), .ival(ival), .idata_i(di), .idata_q(dq), .iexp(iexp),
    .ieop(ieop), .threshold(threshold), .opeak_mag(opeak_mag), .opeak_idx(opeak_idx),
    .oexp(oexp), .odet(odet), .oerr(oerr), .oval(oval));

  xcorr_peak_detect #(.IDX_W(3), .MAG_W(32), .PAR_SHIFT(PAR_SHIFT)) dut3 (
    .clk(clk), .rst(rst), .ival(ival), .idata_i(di), .idata_q(dq), .iexp(iexp),
    .ieop(ieop), .threshold(threshold), .opeak_mag(p3_mag), .opeak_idx(p3_idx),
    .oexp(p3_exp), .odet(p3_det), .oerr(p3_err), .oval(p3_val));

  int n_chk = 0, n_pass = 0, cyc = 0, oval_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- frame-level reference model ----------------
  typedef struct { int due; longint mag; longint sum; int idx; int e; bit err; } res_t;
  longint fq[$];
  res_t   pend[$];
  logic [31:0] h_mag;
  logic [9:0]  h_idx;
  logic [4:0]  h_exp;
  logic        h_det, h_err, h_val;

  function automatic bit model_det(longint m, longint s, longint t);
    bit d;
    d = m > t;
`ifdef XCORR_PEAK_PAR_EN
    d = d && ((m << PAR_SHIFT) > s);
`endif
    return d;
  endfunction

  task automatic model_edge();
    longint m, best, s;
    int bi;
    res_t r;
    h_val = 1'b0;
    if (rst) begin
      fq.delete(); pend.delete();
      h_mag = '0; h_idx = '0; h_exp = '0; h_det = 1'b0; h_err = 1'b0;
      return;
    end
    if (pend.size() > 0 && pend[0].due == cyc) begin
      r = pend.pop_front();
      h_val = 1'b1; h_mag = 32'(r.mag); h_idx = 10'(r.idx); h_exp = 5'(r.e);
      h_err = r.err; h_det = model_det(r.mag, r.sum, longint'(threshold));
    end
    if (ival) begin
      m = longint'(di) * longint'(di) + longint'(dq) * longint'(dq);
      fq.push_back(m);
      if (ieop) begin
        best = -1; bi = 0; s = 0;
        foreach (fq[k]) begin
          s += fq[k];
          if (fq[k] > best) begin best = fq[k]; bi = k; end
        end
        r.due = cyc + 3; r.mag = best; r.sum = s; r.e = int'(iexp);
        r.idx = (bi > 1023) ? 1023 : bi;
        r.err = fq.size() > 1024;
        pend.push_back(r);
        fq.delete();
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    if (oval) oval_cnt++;
    chk("tick", {oval, odet, oerr, oexp, opeak_idx, opeak_mag},
                {h_val, h_det, h_err, h_exp, h_idx, h_mag});
  endtask

  task automatic drive(input bit v, input int i, input int q, input int e, input bit eop);
    ival = v; di = 16'(i); dq = 16'(q); iexp = 5'(e); ieop = eop;
    tick();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 0, 0, 0, 1'b0);
  endtask

  // ---------------- vector table ----------------
  typedef struct { int pa; int pb; int vi; int vq; int e; longint thr;
                   longint emag; int eidx; bit edet; } vec_t;
  vec_t vt[6];

  int base_cnt;
  bit par_det;

  initial begin
    vt[0] = '{5, -1,    100,   -200,  3,     0, 50000, 5, 1'b1};
    vt[1] = '{2,  6,    100,   -200,  7, 49999, 50000, 2, 1'b1};
    vt[2] = '{2,  6,    100,   -200,  7, 50000, 50000, 2, 1'b0};
    vt[3] = '{4, -1, -32768, -32768, 13,     0, 64'h8000_0000, 4, 1'b1};
    vt[4] = '{0, -1,      3,      4,  1,   100,    25, 0, 1'b0};
    vt[5] = '{7, -1,      0,     -5, 31,    24,    25, 7, 1'b1};

    rst = 1'b1; ival = 1'b0; ieop = 1'b0; di = '0; dq = '0; iexp = '0; threshold = '0;
    tick(); tick();
    chk("reset_out", {oval, odet, oerr, oexp, opeak_idx, opeak_mag}, 64'd0);
    chk("reset_out3", {p3_val, p3_det, p3_err, p3_exp, p3_idx, p3_mag}, 64'd0);
    rst = 1'b0;
    idle(2);

    for (int v = 0; v < 6; v++) begin
      threshold = 32'(vt[v].thr);
      for (int k = 0; k < 8; k++) begin
        if (k == vt[v].pa || k == vt[v].pb) drive(1'b1, vt[v].vi, vt[v].vq, vt[v].e, k == 7);
        else                                drive(1'b1, 1, 1, vt[v].e, k == 7);
      end
      idle(2);
      chk("vec_oval_early", 64'(oval), 64'd0);
      idle(1);
      chk("vec_oval", 64'(oval), 64'd1);
      chk("vec_mag", 64'(opeak_mag), 64'(vt[v].emag));
      chk("vec_idx", 64'(opeak_idx), 64'(vt[v].eidx));
      chk("vec_det", 64'(odet), 64'(vt[v].edet));
      chk("vec_exp", 64'(oexp), 64'(vt[v].e));
      chk("vec_err", 64'(oerr), 64'd0);
      idle(1);
      chk("vec_oval_pulse", 64'(oval), 64'd0);
      chk("vec_hold", 64'(opeak_mag), 64'(vt[v].emag));
    end

    // Back-to-back frames with gaps: A peaks at idx 3, B at its first (small) sample.
    threshold = 0;
    base_cnt = oval_cnt;
    begin
      int ai[6] = '{1, 2, 1, 50, 3, 2};
      int aq[6] = '{1, 2, 0, 50, 3, 0};
      int bi[4] = '{2, 1, 1, 0};
      int bq[4] = '{0, 0, 1, 1};
      for (int k = 0; k < 6; k++) begin
        if (k > 0) idle($urandom_range(0, 2));
        drive(1'b1, ai[k], aq[k], 9, k == 5);
      end
      for (int k = 0; k < 4; k++) begin
        if (k > 0) idle($urandom_range(0, 2));
        drive(1'b1, bi[k], bq[k], 11, k == 3);
      end
    end
    idle(3);
    chk("b2b_ovals", 64'(oval_cnt - base_cnt), 64'd2);
    chk("b2b_idx", 64'(opeak_idx), 64'd0);
    chk("b2b_mag", 64'(opeak_mag), 64'd4);
    chk("b2b_exp", 64'(oexp), 64'd11);

    // Reset with an eop in flight, then reset mid-frame (rst also overrides ival).
    base_cnt = oval_cnt;
    drive(1'b1, 9, 9, 2, 1'b0);
    drive(1'b1, 1, 1, 2, 1'b1);
    rst = 1'b1; drive(1'b0, 0, 0, 0, 1'b0); rst = 1'b0;
    drive(1'b1, 1, 1, 4, 1'b0);
    drive(1'b1, 100, 100, 4, 1'b0);
    drive(1'b1, 1, 1, 4, 1'b0);
    rst = 1'b1; drive(1'b1, 120, 120, 4, 1'b1); rst = 1'b0;
    drive(1'b1, 1, 0, 6, 1'b0);
    drive(1'b1, 2, 0, 6, 1'b0);
    drive(1'b1, 5, 5, 6, 1'b0);
    drive(1'b1, 1, 1, 6, 1'b1);
    idle(3);
    chk("rst_ovals", 64'(oval_cnt - base_cnt), 64'd1);
    chk("rst_idx", 64'(opeak_idx), 64'd2);
    chk("rst_mag", 64'(opeak_mag), 64'd50);

    // Oversize frame on the IDX_W=3 instance: 10 samples, largest last.
    rst = 1'b1; idle(1); rst = 1'b0;
    for (int k = 0; k < 10; k++) drive(1'b1, k + 1, 0, 5, k == 9);
    idle(3);
    chk("ovr_val3", 64'(p3_val), 64'd1);
    chk("ovr_err3", 64'(p3_err), 64'd1);
    chk("ovr_idx3", 64'(p3_idx), 64'd7);
    chk("ovr_mag3", 64'(p3_mag), 64'd100);
    for (int k = 0; k < 4; k++) drive(1'b1, (k == 1) ? 7 : 1, 0, 5, k == 3);
    idle(3);
    chk("ovr_clear_err3", 64'(p3_err), 64'd0);
    chk("ovr_clear_idx3", 64'(p3_idx), 64'd1);

    // Peak-to-average: 16 equal bins, then one dominant bin.
`ifdef XCORR_PEAK_PAR_EN
    par_det = 1'b0;
`else
    par_det = 1'b1;
`endif
    threshold = 0;
    for (int k = 0; k < 16; k++) drive(1'b1, 10, 0, 1, k == 15);
    idle(3);
    chk("par_flat_det", 64'(odet), 64'(par_det));
    for (int k = 0; k < 16; k++) drive(1'b1, (k == 5) ? 100 : 10, 0, 1, k == 15);
    idle(3);
    chk("par_peak_det", 64'(odet), 64'd1);
    chk("par_peak_idx", 64'(opeak_idx), 64'd5);

    // Randomized frames against the model.
    begin
      int e;
      bit v, eop;
      int ri, rq;
      e = $urandom_range(0, 31);
      for (int n = 0; n < 600; n++) begin
        if ($urandom_range(0, 15) == 0) threshold = $urandom_range(0, 60000);
        v   = $urandom_range(0, 9) < 7;
        eop = v && ($urandom_range(0, 7) == 0);
        ri  = ($urandom_range(0, 3) == 0) ? int'($signed(16'($urandom))) : int'($urandom_range(0, 200)) - 100;
        rq  = ($urandom_range(0, 3) == 0) ? int'($signed(16'($urandom))) : int'($urandom_range(0, 200)) - 100;
        drive(v, ri, rq, e, eop);
        if (eop) e = $urandom_range(0, 31);
      end
      drive(1'b1, 3, 3, e, 1'b1);
      idle(4);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
